// File: rtl/mult_pkg.sv
// Shared types and constants for the iterative multiplier.
// Provides the FSM state enum and the default operand width.
package mult_pkg;

  localparam int MULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SIGN = 2'd2
  } state_t;

endpackage

// File: rtl/mult_datapath.sv
// Radix-2 shift-add datapath with sign correction.
// Ports: clk, rst_n, load/step/commit strobes, signed_op, a, b in;
// result (2*WIDTH, valid while commit is high) out.
module mult_datapath
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic               commit,
  input  logic               signed_op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] result
);

  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   mplier;
  logic               neg;

  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;

  // Most-negative value negates to its own bit pattern, which is
  // exactly its unsigned magnitude.
  always_comb begin
    mag_a = a;
    mag_b = b;
    if (signed_op && a[WIDTH-1]) mag_a = -a;
    if (signed_op && b[WIDTH-1]) mag_b = -b;
  end

  always_comb begin
    sum = {1'b0, acc_hi};
    if (mplier[0]) sum = {1'b0, acc_hi} + {1'b0, mcand};
  end

  // The multiplier register doubles as the low half of the product
  // as bits shift in from the top.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand  <= '0;
      acc_hi <= '0;
      mplier <= '0;
      neg    <= 1'b0;
    end else if (load) begin
      mcand  <= mag_a;
      acc_hi <= '0;
      mplier <= mag_b;
      neg    <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
    end else if (step) begin
      acc_hi <= sum[WIDTH:1];
      mplier <= {sum[0], mplier[WIDTH-1:1]};
    end
  end

  always_comb begin
    prod   = {acc_hi, mplier};
    result = '0;
    if (commit) result = neg ? -prod : prod;
  end

endmodule

// File: rtl/mult_controller.sv
// Sequencer for MULT/MULTU: FSM, step counter, HI/LO and done.
// Ports: clk, rst_n, start_multD, signedD, srcA, srcB, we_hi, we_lo,
// wd in; mult_active, hi, lo, done out.
module mult_controller
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_multD,
  input  logic             signedD,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             we_hi,
  input  logic             we_lo,
  input  logic [WIDTH-1:0] wd,
  output logic             mult_active,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             done
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state;
  state_t state_nxt;

  logic [CW-1:0]      cnt;
  logic               load;
  logic               step;
  logic               commit;
  logic [2*WIDTH-1:0] result;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start_multD) state_nxt = RUN;
      RUN:  if (cnt == LAST) state_nxt = SIGN;
      SIGN: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mult_active = 1'b0;
    load        = 1'b0;
    step        = 1'b0;
    commit      = 1'b0;
    unique case (state)
      IDLE: load = start_multD;
      RUN: begin
        mult_active = 1'b1;
        step        = 1'b1;
      end
      SIGN: begin
        mult_active = 1'b1;
        commit      = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n)    cnt <= '0;
    else if (load) cnt <= '0;
    else if (step) cnt <= cnt + 1'b1;
  end

  // Product commit has priority over MTHI/MTLO on the SIGN edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi <= '0;
      lo <= '0;
    end else if (commit) begin
      hi <= result[2*WIDTH-1:WIDTH];
      lo <= result[WIDTH-1:0];
    end else begin
      if (we_hi) hi <= wd;
      if (we_lo) lo <= wd;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) done <= 1'b0;
    else        done <= commit;
  end

  mult_datapath #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .step     (step),
    .commit   (commit),
    .signed_op(signedD),
    .a        (srcA),
    .b        (srcB),
    .result   (result)
  );

endmodule
